// File: rtl/cache_refill_ctrl.sv
// Miss handler for the direct-mapped cache. It fetches one line from memory a word at a time and fills the data array.
// Build option CRIT_WORD_FIRST_EN: fetch the requested word first, then wrap around the rest of the line.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for a miss; miss_ready=1
//   REQ      | presenting a word read request until memory takes it
//   WAIT     | one request outstanding; waiting for its response
//   FILL_END | last word being written; fill_done pulses
module cache_refill_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done,
    output logic              crit_valid,
    output logic [DATA_W-1:0] crit_data,
    output logic              busy
);

    localparam int OFS_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - OFS_W - 2;
    localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT     = 2'd2,
        FILL_END = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [TAG_W-1:0]  line_tag;
    logic [OFS_W-1:0]  crit_ofs;
    logic [OFS_W-1:0]  beat;
    logic [OFS_W-1:0]  word_idx;
    logic [ADDR_W-1:0] word_addr;
    logic              accept;
    logic              rsp_take;
    logic              unused_byte_ofs;

    // The byte offset selects nothing here; the cache handles byte lanes itself.
    assign unused_byte_ofs = ^miss_addr[1:0];

`ifdef CRIT_WORD_FIRST_EN
    assign word_idx = crit_ofs + beat;
`else
    assign word_idx = beat;
`endif

    // The offset field is replaced rather than added, so the address can never carry into the tag.
    assign word_addr = {line_tag, word_idx, 2'b00};

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        rsp_take      = 1'b0;
        miss_ready    = 1'b0;
        busy          = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        fill_done     = 1'b0;
        case (state)
            IDLE: begin
                miss_ready = 1'b1;
                busy       = 1'b0;
                if (miss_valid) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = word_addr;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = (beat == LAST_BEAT) ? FILL_END : REQ;
                end
            end
            FILL_END: begin
                fill_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            line_tag   <= '0;
            crit_ofs   <= '0;
            beat       <= '0;
            fill_we    <= 1'b0;
            fill_addr  <= '0;
            fill_data  <= '0;
            crit_valid <= 1'b0;
            crit_data  <= '0;
        end else begin
            state      <= state_next;
            fill_we    <= rsp_take;
            crit_valid <= rsp_take && (word_idx == crit_ofs);
            if (accept) begin
                line_tag <= miss_addr[ADDR_W-1:OFS_W+2];
                crit_ofs <= miss_addr[OFS_W+1:2];
                beat     <= '0;
            end
            if (rsp_take) begin
                beat      <= beat + OFS_W'(1);
                fill_addr <= word_addr;
                fill_data <= mem_rsp_data;
                if (word_idx == crit_ofs) begin
                    crit_data <= mem_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl. A vector table drives whole refills against a memory model that returns data equal to the address.
// It also runs hand-written sequences for reset during a refill and for a stray response while idle.
module tb_cache_refill_ctrl;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int WPL = 4;

    logic          clk;
    logic          rst_n;
    logic          miss_valid;
    logic [AW-1:0] miss_addr;
    logic          miss_ready;
    logic          mem_req_valid;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_ready;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    logic          fill_we;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          fill_done;
    logic          crit_valid;
    logic [DW-1:0] crit_data;
    logic          busy;

    cache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .rst_n(rst_n),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data), .fill_done(fill_done),
        .crit_valid(crit_valid), .crit_data(crit_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0]       addr;
        logic [3:0][31:0]  exp_a;      // expected request address per beat
        int                crit_beat;
        int                stall_beat;
        int                stall_cyc;
        bit                stray;      // stray response during the first stall cycle
        bit                busy_miss;  // raise miss 0x1000 during beat 1 and leave it held
        bit                pre;        // miss already presented by the previous vector
    } vec_t;

    vec_t tv [5];

    function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3, input int cb, input int sb,
                                input int sc, input bit st, input bit bm, input bit pr);
        vec_t v;
        v.addr = addr;
        v.exp_a = {a3, a2, a1, a0};
        v.crit_beat = cb;
        v.stall_beat = sb;
        v.stall_cyc = sc;
        v.stray = st;
        v.busy_miss = bm;
        v.pre = pr;
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".miss_ready"}, 32'(miss_ready), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, ".fill_we"}, 32'(fill_we), 32'd0);
        chk({tag, ".fill_done"}, 32'(fill_done), 32'd0);
        chk({tag, ".crit_valid"}, 32'(crit_valid), 32'd0);
    endtask

    task automatic do_refill(input int idx, input vec_t v);
        int    edges;
        int    fills;
        string t;
        t = $sformatf("v%0d", idx);
        edges = 0;
        fills = 0;
        if (!v.pre) begin
            @(negedge clk);
            miss_valid = 1'b1;
            miss_addr  = v.addr;
        end
        chk({t, ".accept_ready"}, 32'(miss_ready), 32'd1);
        @(posedge clk);
        edges++;
        @(negedge clk);
        miss_valid = 1'b0;
        miss_addr  = 32'hAAAA_AAAA;
        for (int b = 0; b < WPL; b++) begin
            chk($sformatf("%s.b%0d.req_valid", t, b), 32'(mem_req_valid), 32'd1);
            chk($sformatf("%s.b%0d.req_addr", t, b), mem_req_addr, v.exp_a[b]);
            if (v.busy_miss && b == 1) begin
                miss_valid = 1'b1;
                miss_addr  = 32'h0000_1000;
                chk({t, ".busy_miss_ready"}, 32'(miss_ready), 32'd0);
            end
            if (b == v.stall_beat) begin
                for (int s = 0; s < v.stall_cyc; s++) begin
                    mem_rsp_valid = v.stray && (s == 0);
                    mem_rsp_data  = 32'hDEAD_BEEF;
                    @(posedge clk);
                    edges++;
                    @(negedge clk);
                    mem_rsp_valid = 1'b0;
                    chk($sformatf("%s.b%0d.stall%0d.valid", t, b, s), 32'(mem_req_valid), 32'd1);
                    chk($sformatf("%s.b%0d.stall%0d.addr", t, b, s), mem_req_addr, v.exp_a[b]);
                    chk($sformatf("%s.b%0d.stall%0d.fill_we", t, b, s), 32'(fill_we), 32'd0);
                end
            end
            mem_req_ready = 1'b1;
            @(posedge clk);
            edges++;
            @(negedge clk);
            mem_req_ready = 1'b0;
            chk($sformatf("%s.b%0d.wait_valid", t, b), 32'(mem_req_valid), 32'd0);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.exp_a[b];
            @(posedge clk);
            edges++;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
            if (fill_we === 1'b1) fills++;
            chk($sformatf("%s.b%0d.fill_addr", t, b), fill_addr, v.exp_a[b]);
            chk($sformatf("%s.b%0d.fill_data", t, b), fill_data, v.exp_a[b]);
            chk($sformatf("%s.b%0d.crit_valid", t, b), 32'(crit_valid), 32'(b == v.crit_beat));
            if (b == v.crit_beat)
                chk($sformatf("%s.b%0d.crit_data", t, b), crit_data, v.exp_a[b]);
            chk($sformatf("%s.b%0d.fill_done", t, b), 32'(fill_done), 32'(b == WPL - 1));
        end
        chk({t, ".latency"}, 32'(edges), 32'(9 + v.stall_cyc));
        chk({t, ".fill_count"}, 32'(fills), 32'(WPL));
        @(posedge clk);
        @(negedge clk);
        check_idle({t, ".after"});
    endtask

    initial begin
        rst_n = 1'b0;
        miss_valid = 1'b0;
        miss_addr = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;

`ifdef CRIT_WORD_FIRST_EN
        tv[0] = mk(32'h0000_005F, 32'h5C, 32'h50, 32'h54, 32'h58, 0, 0, 0, 0, 0, 0);
        tv[1] = mk(32'h0000_0058, 32'h58, 32'h5C, 32'h50, 32'h54, 0, 1, 3, 0, 0, 0);
        tv[4] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 0, 0, 0, 0, 0, 0);
`else
        tv[0] = mk(32'h0000_005F, 32'h50, 32'h54, 32'h58, 32'h5C, 3, 0, 0, 0, 0, 0);
        tv[1] = mk(32'h0000_0058, 32'h50, 32'h54, 32'h58, 32'h5C, 2, 1, 3, 0, 0, 0);
        tv[4] = mk(32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 0, 0, 0, 0, 0);
`endif
        tv[2] = mk(32'h1234_5671, 32'h1234_5670, 32'h1234_5674, 32'h1234_5678, 32'h1234_567C, 0, 2, 1, 1, 1, 0);
        tv[3] = mk(32'h0000_1000, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 0, 0, 0, 0, 0, 1);

        #12;
        check_idle("reset");
        chk("reset.req_addr", mem_req_addr, 32'h0);
        chk("reset.fill_addr", fill_addr, 32'h0);
        chk("reset.fill_data", fill_data, 32'h0);
        chk("reset.crit_data", crit_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during the second WAIT of a refill of 0x5F.
        @(negedge clk);
        miss_valid = 1'b1;
        miss_addr  = 32'h5F;
        @(posedge clk);
        @(negedge clk);
        miss_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h50;
        @(posedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rst_mid.in_wait_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle("rst_mid");
        chk("rst_mid.fill_addr", fill_addr, 32'h0);
        chk("rst_mid.fill_data", fill_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h54;
        @(posedge clk);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_idle("stray_idle");

        for (int i = 0; i < 5; i++) begin
            do_refill(i, tv[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
Miss handler downstream of the direct-mapped cache. Accepts a miss address from the cache, fetches the full line from main memory one word at a time over a valid/ready request and valid-only response channel, and writes each word into the cache data array. Also returns the requested (critical) word to the cache for Data_Out forwarding. Strictly one miss in flight.

Parameters:
ADDR_W, 32, address width in bits (byte address)
DATA_W, 32, word width in bits
WORDS_PER_LINE, 4, words per cache line; power of 2, at least 2
OFS_W, $clog2(WORDS_PER_LINE), word-offset width (localparam)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_valid  in  1  cache has a miss pending
miss_addr  in  ADDR_W  byte address of the missing access
miss_ready  out  1  controller idle and can accept a miss
mem_req_valid  out  1  word read request to memory
mem_req_addr  out  ADDR_W  word-aligned byte address requested
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  read data valid (one per accepted request, in order)
mem_rsp_data  in  DATA_W  read data
fill_we  out  1  write strobe into the cache data array
fill_addr  out  ADDR_W  word-aligned byte address of the word being filled
fill_data  out  DATA_W  word being filled
fill_done  out  1  one-cycle pulse: last word written; cache sets valid and tag
crit_valid  out  1  one-cycle pulse: requested word available
crit_data  out  DATA_W  requested word
busy  out  1  refill in progress

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except miss_ready=1. Any refill is aborted immediately; a mem_rsp_valid arriving afterwards while IDLE is ignored.
- Address split: bits [1:0] byte offset (ignored); bits [OFS_W+1:2] word offset; line base = miss_addr with bits [OFS_W+1:0] cleared.
- States: IDLE, REQ, WAIT, FILL_END.
- IDLE: miss_ready=1, busy=0. On miss_valid&&miss_ready, latch line base and crit offset, beat counter=0, next state REQ. miss_addr is sampled only in that cycle.
- REQ: mem_req_valid=1, busy=1. mem_req_addr = base + (word_idx<<2), with word_idx = beat counter (default order). mem_req_addr is stable while mem_req_valid is high and ready is low. On mem_req_ready, go to WAIT. mem_req_valid drops in WAIT.
- WAIT: on mem_rsp_valid, register fill_we=1, fill_addr, and fill_data for exactly one cycle, starting on the next edge.
  - If word_idx == crit offset, also pulse crit_valid with crit_data=mem_rsp_data in that same registered cycle.
  - If the beat counter is WORDS_PER_LINE-1, go to FILL_END. Otherwise increment the counter and go back to REQ.
- Memory may assert mem_req_ready and mem_rsp_valid in the same cycle only for different requests. Because there is only one outstanding request, a response is only legal in WAIT; mem_rsp_valid in IDLE or REQ is ignored.
- FILL_END: fill_done=1 for one cycle, coinciding with the fill_we of the last word. Next cycle is IDLE with miss_ready=1. Minimum back-to-back miss spacing: the new miss is accepted the cycle after FILL_END.
- Minimum refill latency with zero-wait memory (ready same cycle, response next cycle): 1 + 2*WORDS_PER_LINE + 1 cycles from miss acceptance to fill_done.
- Counter wraps modulo WORDS_PER_LINE. Address arithmetic stays within the line; no carry into the tag bits.
- miss_valid while busy is not accepted (miss_ready=0). The cache must hold it.

Optional Feature:
CRIT_WORD_FIRST_EN
- Defined: word_idx = (crit offset + beat counter) mod WORDS_PER_LINE. The first request is the critical word, and the order wraps around the line. crit_valid therefore occurs on the first fill_we.
- Undefined: sequential order from word 0 as described above. crit_valid occurs on whichever beat matches the crit offset.
- fill_done timing, beat count, and total latency are identical in both builds.

Test Plan:
- Reset mid-refill: accept miss 0x5F and drop rst_n during the second WAIT -> all outputs 0 and miss_ready=1 immediately. A subsequent stray mem_rsp_valid produces no fill_we.
- Basic refill, zero-wait memory returning data=addr: miss_addr=0x0000005F -> mem_req_addr sequence 0x50, 0x54, 0x58, 0x5C. fill_we occurs 4 times with matching data. crit_valid is asserted with crit_data=0x5C on the 4th beat. fill_done is asserted 10 cycles after acceptance.
- Critical-word-first build: miss_addr=0x00000058 -> request order 0x58, 0x5C, 0x50, 0x54. crit_valid is asserted on the first fill_we with data 0x58.
- Backpressure: hold mem_req_ready=0 for 3 cycles on beat 1 -> mem_req_valid stays high with mem_req_addr stable at 0x54. There is no extra fill_we, and the total is 3 cycles longer.
- Miss while busy: assert miss_valid with 0x1000 during a refill -> miss_ready=0 and the address is not latched. It is accepted the cycle after fill_done, and requests start at 0x1000.
- Stray response: mem_rsp_valid=1 while in REQ -> ignored. The fill count remains exactly WORDS_PER_LINE per miss.
